// File: rtl/seq_multiplier_pkg.sv
// Shared types and constants for the sequential multiplier.
// Holds the FSM state encoding and the default operand width.
package seq_multiplier_pkg;

  localparam int DEF_WIDTH = 7;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/seq_multiplier_if.sv
// Request/result bundle for seq_multiplier.
// master: start/is_signed/A/B out, S/ready/done in; slave is the mirror.
interface seq_multiplier_if
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic               start;
  logic               is_signed;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2*WIDTH-1:0] S;
  logic               ready;
  logic               done;

  modport master (
    output start, is_signed, A, B,
    input  S, ready, done
  );

  modport slave (
    input  start, is_signed, A, B,
    output S, ready, done
  );

endinterface

// File: rtl/seq_mult_datapath.sv
// Shift-add datapath: magnitude load, per-cycle add/shift, final negate.
// Ports: clk, rst, load/step/finish controls, a, b, is_signed in; s out.
module seq_mult_datapath
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               finish,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] s
);

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               neg;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_nxt;

  // Most-negative value negates to 2^(WIDTH-1), which still fits
  // in WIDTH bits when read as unsigned.
  function automatic logic [WIDTH-1:0] mag(
    input logic [WIDTH-1:0] x,
    input logic             sg
  );
    return (sg && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
  endfunction

  // {hi,lo} is the product register; lo starts as the multiplier
  // and is consumed LSB-first while the partial sum fills in from hi.
  assign sum      = {1'b0, hi} +
                    ({1'b0, mcand} & {(WIDTH+1){lo[0]}});
  assign prod_nxt = {sum, lo[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      neg   <= 1'b0;
      s     <= '0;
    end else if (load) begin
      mcand <= mag(a, is_signed);
      hi    <= '0;
      lo    <= mag(b, is_signed);
      neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (step) begin
      hi <= prod_nxt[2*WIDTH-1:WIDTH];
      lo <= prod_nxt[WIDTH-1:0];
      if (finish)
        s <= neg ? (~prod_nxt + (2*WIDTH)'(1)) : prod_nxt;
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative signed/unsigned multiplier, WIDTH cycles per product.
// Ports: clk, rst; bus (slave): start/is_signed/A/B in, S/ready/done out.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic clk,
  input  logic rst,
  seq_multiplier_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              ready;
  logic              done;
  logic              load;
  logic              step;
  logic              finish;
  logic [2*WIDTH-1:0] s;

  assign load   = (state == IDLE) && bus.start;
  assign step   = (state == BUSY);
  assign finish = step && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ready <= 1'b1;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state <= BUSY;
            ready <= 1'b0;
          end
        end
        BUSY: begin
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
            cnt   <= '0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          done  <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

  seq_mult_datapath #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .finish    (finish),
    .is_signed (bus.is_signed),
    .a         (bus.A),
    .b         (bus.B),
    .s         (s)
  );

  assign bus.S     = s;
  assign bus.ready = ready;
  assign bus.done  = done;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and golden-model checks for seq_multiplier at WIDTH=7.
// Drives the interface master side and checks S/ready/done.
module tb_seq_multiplier;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_bad;

  seq_multiplier_if #(.WIDTH(7)) bus ();

  seq_multiplier #(.WIDTH(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One operation: returns result, done latency and ready-low count.
  task automatic run_op(input  logic [6:0]  a,
                        input  logic [6:0]  b,
                        input  logic        sg,
                        output logic [13:0] res,
                        output int          lat,
                        output int          rdy_low);
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.is_signed = sg;
    bus.start = 1'b1;
    lat = 0;
    rdy_low = 0;
    res = '0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.A = ~a;
      bus.B = ~b;
      bus.is_signed = ~sg;
      if (!bus.ready) rdy_low++;
      if (bus.done) begin
        lat = i;
        res = bus.S;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [13:0] res;
  int          lat;
  int          rl;
  int          pulses;
  logic [6:0]  ra;
  logic [6:0]  rb;
  logic        rs;
  int          sa;
  int          sb;
  logic [13:0] exp_p;

  initial begin
    n_chk = 0;
    n_bad = 0;
    bus.start = 1'b0;
    bus.is_signed = 1'b0;
    bus.A = '0;
    bus.B = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_S", 32'(bus.S), 0);
    chk("rst_ready", 32'(bus.ready), 1);
    chk("rst_done", 32'(bus.done), 0);
    @(negedge clk);
    rst = 1'b0;

    run_op(7'd127, 7'd127, 1'b0, res, lat, rl);
    chk("u127_S", 32'(res), 32'h3F01);
    chk("u127_lat", 32'(lat), 8);
    chk("u127_rdylow", 32'(rl), 8);
    chk("u127_ready_back", 32'(bus.ready), 1);
    chk("u127_done_pulse", 32'(bus.done), 0);
    chk("u127_S_hold", 32'(bus.S), 32'h3F01);

    run_op(7'h7D, 7'd5, 1'b1, res, lat, rl);
    chk("s_m3x5", 32'(res), 32'h3FF1);
    run_op(7'h40, 7'h40, 1'b1, res, lat, rl);
    chk("s_m64xm64", 32'(res), 32'h1000);
    run_op(7'h40, 7'd63, 1'b1, res, lat, rl);
    chk("s_m64x63", 32'(res), 32'h3040);
    run_op(7'h40, 7'd63, 1'b0, res, lat, rl);
    chk("u_64x63", 32'(res), 32'd4032);

    run_op(7'd0, 7'd99, 1'b0, res, lat, rl);
    chk("zero_S", 32'(res), 0);
    chk("zero_lat", 32'(lat), 8);

    // second start while busy must be ignored
    @(negedge clk);
    bus.A = 7'd10;
    bus.B = 7'd10;
    bus.is_signed = 1'b0;
    bus.start = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk);
      #1;
      bus.start = (i == 3);
      bus.A = (i == 3) ? 7'd2 : 7'd10;
      bus.B = (i == 3) ? 7'd2 : 7'd10;
      if (bus.done) begin
        pulses++;
        res = bus.S;
      end
    end
    bus.start = 1'b0;
    chk("busy_S", 32'(res), 32'd100);
    chk("busy_pulses", 32'(pulses), 1);

    // reset mid-operation
    @(negedge clk);
    bus.A = 7'd9;
    bus.B = 7'd9;
    bus.start = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_ready", 32'(bus.ready), 1);
    chk("abort_S", 32'(bus.S), 0);
    chk("abort_done", 32'(bus.done), 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) pulses++;
    end
    chk("abort_nodone", 32'(pulses), 0);
    run_op(7'd9, 7'd9, 1'b0, res, lat, rl);
    chk("after_abort_S", 32'(res), 32'd81);
    chk("after_abort_lat", 32'(lat), 8);

    // golden model, both modes
    for (int k = 0; k < 1000; k++) begin
      ra = 7'($urandom_range(0, 127));
      rb = 7'($urandom_range(0, 127));
      rs = k[0];
      sa = rs ? {{25{ra[6]}}, ra} : {25'b0, ra};
      sb = rs ? {{25{rb[6]}}, rb} : {25'b0, rb};
      exp_p = 14'(sa * sb);
      run_op(ra, rb, rs, res, lat, rl);
      chk("rand_S", 32'(res), 32'(exp_p));
      chk("rand_lat", 32'(lat), 8);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
